// File: rtl/usb_tx_scheduler.sv
// Round-robin scheduler sharing one USB transmit path between two 64-bit requesters.
// Accept -> start pulse next cycle; ack timeout triggers bounded retries; idle gap after every attempt.
module usb_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 8,
  parameter int MAX_RETRY      = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req0_valid,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  input  logic        handshake_ack,
  output logic        trans_data_ready,
  output logic [63:0] trans_data,
  output logic        busy,
  output logic        grant,
  output logic        tx_done,
  output logic        tx_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 1);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_ACK, GAP} state_t;

  state_t        state_q, state_d;
  logic [63:0]   data_q, data_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [RW-1:0] retry_cnt_q, retry_cnt_d;
  logic          retry_pending_q, retry_pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          tx_done_q, tx_done_d;
  logic          tx_err_q, tx_err_d;
  logic          pick1;

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  assign pick1 = req1_valid && (!req0_valid || !last_grant_q);

  always_comb begin
    state_d          = state_q;
    data_d           = data_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    retry_cnt_d      = retry_cnt_q;
    retry_pending_d  = retry_pending_q;
    timer_d          = timer_q;
    gap_cnt_d        = gap_cnt_q;
    tx_done_d        = 1'b0;
    tx_err_d         = 1'b0;
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    trans_data_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          req0_ready   = !pick1;
          req1_ready   = pick1;
          data_d       = pick1 ? req1_data : req0_data;
          grant_d      = pick1;
          last_grant_d = pick1;
          retry_cnt_d  = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        trans_data_ready = 1'b1;
        timer_d          = '0;
        state_d          = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (handshake_ack) begin
          tx_done_d       = 1'b1;
          retry_pending_d = 1'b0;
          gap_cnt_d       = '0;
          state_d         = GAP;
        end else if (timer_q == TIMER_LAST) begin
          gap_cnt_d = '0;
          state_d   = GAP;
          if (retry_cnt_q < MAX_RETRY_C) begin
            retry_cnt_d     = retry_cnt_q + 1'b1;
            retry_pending_d = 1'b1;
          end else begin
            tx_err_d        = 1'b1;
            retry_pending_d = 1'b0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = retry_pending_q ? LOAD : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      data_q          <= '0;
      grant_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      retry_cnt_q     <= '0;
      retry_pending_q <= 1'b0;
      timer_q         <= '0;
      gap_cnt_q       <= '0;
      tx_done_q       <= 1'b0;
      tx_err_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      data_q          <= data_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      retry_cnt_q     <= retry_cnt_d;
      retry_pending_q <= retry_pending_d;
      timer_q         <= timer_d;
      gap_cnt_q       <= gap_cnt_d;
      tx_done_q       <= tx_done_d;
      tx_err_q        <= tx_err_d;
    end
  end

  assign trans_data = data_q;
  assign busy       = (state_q != IDLE);
  assign grant      = grant_q;
  assign tx_done    = tx_done_q;
  assign tx_err     = tx_err_q;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Directed bench for usb_tx_scheduler with a scoreboard of expected packet outcomes.
module tb_usb_tx_scheduler;

  localparam logic [63:0] D1  = 64'hDEADBEEF_01234567;
  localparam logic [63:0] DAA = 64'hAAAAAAAA_AAAAAAAA;
  localparam logic [63:0] D55 = 64'h55555555_55555555;
  localparam logic [63:0] D3  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D4  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] D5  = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D6  = 64'hCAFE_F00D_0000_0006;
  localparam logic [63:0] D7  = 64'h7777_0000_7777_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, handshake_ack = 1'b0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready, trans_data_ready, busy, grant, tx_done, tx_err;
  logic [63:0] trans_data;

  typedef struct {
    logic        err;
    logic        grant;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int tdr_cnt = 0, r0_cnt = 0, r1_cnt = 0, done_cnt = 0, err_cnt = 0;
  int s_tdr, s_r0, s_r1, s_done, s_err;

  usb_tx_scheduler #(.TIMEOUT_CYCLES(16), .GAP_CYCLES(2), .MAX_RETRY(1)) dut (
    .clk(clk), .n_rst(n_rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .handshake_ack(handshake_ack),
    .trans_data_ready(trans_data_ready), .trans_data(trans_data),
    .busy(busy), .grant(grant), .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic g, input logic [63:0] d);
    exp_t e;
    e.err = err;
    e.grant = g;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic snap();
    s_tdr = tdr_cnt; s_r0 = r0_cnt; s_r1 = r1_cnt; s_done = done_cnt; s_err = err_cnt;
  endtask

  task automatic do_reset();
    @(negedge clk); n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1;
    #1;
  endtask

  task automatic wait_tdr(input string tag);
    int k = 0;
    while (trans_data_ready !== 1'b1 && k < 100) begin
      @(negedge clk); #1; k++;
    end
    chk1(tag, (k < 100), 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 200) begin
      @(negedge clk); #1; k++;
    end
    chk1(tag, (k < 200), 1'b1);
  endtask

  task automatic send_ack();
    @(negedge clk); handshake_ack = 1'b1;
    @(negedge clk); handshake_ack = 1'b0;
    #1;
  endtask

  // Monitor: counts pulses and retires scoreboard entries on tx_done / tx_err.
  always @(negedge clk) begin
    #2;
    if (req0_ready === 1'b1) r0_cnt++;
    if (req1_ready === 1'b1) r1_cnt++;
    if (trans_data_ready === 1'b1) begin
      tdr_cnt++;
      chk1("sb_tdr_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk64("sb_tdr_data", trans_data, exp_q[0].data);
    end
    if (tx_done === 1'b1 || tx_err === 1'b1) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
      chk1("sb_outcome_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk1("sb_err", tx_err, mon_e.err);
        chk1("sb_done", tx_done, !mon_e.err);
        chk1("sb_grant", grant, mon_e.grant);
        chk64("sb_data", trans_data, mon_e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_grant", grant, 1'b0);
    chk64("rst_data", trans_data, 64'd0);
    chk1("rst_tdr", trans_data_ready, 1'b0);
    chk1("rst_done", tx_done, 1'b0);
    chk1("rst_err", tx_err, 1'b0);
    chk1("rst_r0", req0_ready, 1'b0);

    // Single request, ack 5 cycles after LOAD
    snap();
    @(negedge clk); req0_valid = 1'b1; req0_data = D1; push_exp(1'b0, 1'b0, D1); #1;
    chk1("t1_r0_ready", req0_ready, 1'b1);
    chk1("t1_r1_ready", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk1("t1_tdr", trans_data_ready, 1'b1);
    chk64("t1_data", trans_data, D1);
    chk1("t1_busy", busy, 1'b1);
    chk1("t1_grant", grant, 1'b0);
    repeat (4) @(negedge clk);
    @(negedge clk); handshake_ack = 1'b1; #1;
    chk1("t1_done_early", tx_done, 1'b0);
    @(negedge clk); handshake_ack = 1'b0; #1;
    chk1("t1_done", tx_done, 1'b1);
    @(negedge clk); #1;
    chk1("t1_done_pulse", tx_done, 1'b0);
    chk1("t1_busy_gap", busy, 1'b1);
    @(negedge clk); #1;
    chk1("t1_busy_drop", busy, 1'b0);
    chki("t1_r0_pulses", r0_cnt - s_r0, 1);
    chki("t1_tdr_pulses", tdr_cnt - s_tdr, 1);
    chki("t1_done_pulses", done_cnt - s_done, 1);

    // Contention, fresh reset so req0 wins first
    do_reset();
    snap();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = DAA; req1_data = D55;
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, k[0], k[0] ? D55 : DAA);
      wait_tdr("t2_wait_tdr");
      chk1("t2_grant", grant, k[0]);
      send_ack();
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
    end
    @(negedge clk); #1;
    chki("t2_r0_pulses", r0_cnt - s_r0, 2);
    chki("t2_r1_pulses", r1_cnt - s_r1, 2);
    chki("t2_done_pulses", done_cnt - s_done, 4);
    wait_idle("t2_idle");

    // Timeout, then retry succeeds
    snap();
    @(negedge clk); req0_valid = 1'b1; req0_data = D3; push_exp(1'b0, 1'b0, D3);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk1("t3_tdr1", trans_data_ready, 1'b1);
    repeat (17) @(negedge clk); #1;
    chk1("t3_no_err", tx_err, 1'b0);
    chk1("t3_gap_busy", busy, 1'b1);
    chk1("t3_gap_tdr", trans_data_ready, 1'b0);
    repeat (2) @(negedge clk); #1;
    chk1("t3_tdr2", trans_data_ready, 1'b1);
    chk64("t3_data2", trans_data, D3);
    chk1("t3_grant", grant, 1'b0);
    send_ack();
    chk1("t3_done", tx_done, 1'b1);
    chk1("t3_grant_done", grant, 1'b0);
    chki("t3_tdr_pulses", tdr_cnt - s_tdr, 2);
    chki("t3_err_pulses", err_cnt - s_err, 0);
    wait_idle("t3_idle");

    // Retries exhausted; req1 waiting meanwhile
    snap();
    @(negedge clk); req0_valid = 1'b1; req0_data = D4; push_exp(1'b1, 1'b0, D4);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b1; req1_data = D5; #1;
    chk1("t4_tdr1", trans_data_ready, 1'b1);
    chk1("t4_r1_blocked", req1_ready, 1'b0);
    repeat (19) @(negedge clk); #1;
    chk1("t4_tdr2", trans_data_ready, 1'b1);
    chk64("t4_data2", trans_data, D4);
    repeat (17) @(negedge clk); #1;
    chk1("t4_err", tx_err, 1'b1);
    chk1("t4_no_done", tx_done, 1'b0);
    push_exp(1'b0, 1'b1, D5);
    repeat (2) @(negedge clk); #1;
    chk1("t4_idle", busy, 1'b0);
    chk1("t4_r1_ready", req1_ready, 1'b1);
    chk1("t4_r0_ready", req0_ready, 1'b0);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk1("t4_tdr_r1", trans_data_ready, 1'b1);
    chk1("t4_grant_r1", grant, 1'b1);
    chk64("t4_data_r1", trans_data, D5);
    chki("t4_tdr_pulses", tdr_cnt - s_tdr, 2);
    chki("t4_err_pulses", err_cnt - s_err, 1);
    chki("t4_done_pulses", done_cnt - s_done, 0);
    send_ack();
    chk1("t4_done_r1", tx_done, 1'b1);
    wait_idle("t4_idle2");

    // Ack on the timeout cycle
    snap();
    @(negedge clk); req0_valid = 1'b1; req0_data = D6; push_exp(1'b0, 1'b0, D6);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk1("t5_tdr", trans_data_ready, 1'b1);
    repeat (15) @(negedge clk);
    @(negedge clk); handshake_ack = 1'b1; #1;
    chk1("t5_busy", busy, 1'b1);
    @(negedge clk); handshake_ack = 1'b0; #1;
    chk1("t5_done", tx_done, 1'b1);
    chk1("t5_err", tx_err, 1'b0);
    @(negedge clk); #1;
    chk1("t5_no_retry_a", trans_data_ready, 1'b0);
    @(negedge clk); #1;
    chk1("t5_idle", busy, 1'b0);
    chk1("t5_no_retry_b", trans_data_ready, 1'b0);
    @(negedge clk); #1;
    chki("t5_tdr_pulses", tdr_cnt - s_tdr, 1);
    chki("t5_err_pulses", err_cnt - s_err, 0);

    // Reset in WAIT_ACK abandons the packet
    wait_idle("t6_idle");
    snap();
    @(negedge clk); req1_valid = 1'b1; req1_data = D7; push_exp(1'b0, 1'b1, D7);
    @(negedge clk); req1_valid = 1'b0; #1;
    chk1("t6_tdr", trans_data_ready, 1'b1);
    chk1("t6_grant", grant, 1'b1);
    repeat (3) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk); n_rst = 1'b1; #1;
    exp_q.delete();
    chk1("t6_busy", busy, 1'b0);
    chk1("t6_grant0", grant, 1'b0);
    chk64("t6_data0", trans_data, 64'd0);
    chk1("t6_tdr0", trans_data_ready, 1'b0);
    chk1("t6_done0", tx_done, 1'b0);
    chk1("t6_err0", tx_err, 1'b0);
    chk1("t6_r0_0", req0_ready, 1'b0);
    chk1("t6_r1_0", req1_ready, 1'b0);
    @(negedge clk); handshake_ack = 1'b1; #1;
    chk1("t6_spur_busy", busy, 1'b0);
    @(negedge clk); handshake_ack = 1'b0; #1;
    chk1("t6_spur_done", tx_done, 1'b0);
    chk1("t6_spur_busy2", busy, 1'b0);
    chki("t6_done_pulses", done_cnt - s_done, 0);
    chki("t6_err_pulses", err_cnt - s_err, 0);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_data = DAA; req1_data = D55;
    push_exp(1'b0, 1'b0, DAA); #1;
    chk1("t6_r0_wins", req0_ready, 1'b1);
    chk1("t6_r1_loses", req1_ready, 1'b0);
    @(negedge clk); req0_valid = 1'b0; req1_valid = 1'b0; #1;
    chk1("t6_tdr2", trans_data_ready, 1'b1);
    chk1("t6_grant_r0", grant, 1'b0);
    send_ack();
    chk1("t6_done", tx_done, 1'b1);
    wait_idle("t6_idle2");
    @(negedge clk); #3;
    chki("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
